// File: rtl/otp_clk_gate_ctrl.sv
// otp_clk_gate_ctrl
// Drives the E/TE enables of the latch-based ICG that clocks the OTP macro
// interface logic.
//
// Handshake with the OTP sequencer (level REQ/ACK):
//   - req_i is raised by the sequencer and held until it has finished.
//   - ack_o is registered and rises only once the gated clock has run for
//     WAKE_CYC cycles. It falls on the same edge that samples req_i low.
//   - The sequencer must not assume the clock is running before ack_o=1.
//
// Gate close:
//   - After req_i drops, the gate stays open until act_i has been quiet for
//     IDLE_CYC cycles.
//
// Enable behaviour:
//   - e_o is registered, so the ICG latch only sees it change after a cp_i edge.
//   - force_i overrides e_o only.
//   - te_o is a straight pass-through of se_i.
module otp_clk_gate_ctrl #(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 5
) (
  input  logic       cp_i,
  input  logic       cd_i,
  input  logic       req_i,
  input  logic       act_i,
  input  logic       force_i,
  input  logic       se_i,
  output logic       e_o,
  output logic       te_o,
  output logic       ack_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             ack_q, ack_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (req_i) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (!req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = IDLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ON: begin
        if (!req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_DRAIN: begin
        // Clock never stopped in DRAIN, so a new request goes straight to ON.
        if (req_i) begin
          state_d = ST_ON;
        end else if (act_i) begin
          cnt_d = IDLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    e_d   = (state_d != ST_OFF) | force_i;
    ack_d = (state_d == ST_ON);
  end

  // State, counter and enable registers with synchronous reset
  always_ff @(posedge cp_i) begin
    if (cd_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      e_q     <= force_i;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
    end
  end

  assign e_o     = e_q;
  assign ack_o   = ack_q;
  assign te_o    = se_i;
  assign state_o = state_q;

endmodule

// File: tb/tb_otp_clk_gate_ctrl.sv
// Bench for otp_clk_gate_ctrl: directed scenarios followed by randomized
// segments, checked against an elapsed-time reference model.
module tb_otp_clk_gate_ctrl;

  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 16;

  // Clock/reset block
  logic       clk = 1'b0;
  logic       cd  = 1'b1;
  logic       req = 1'b0;
  logic       act = 1'b0;
  logic       frc = 1'b0;
  logic       se  = 1'b0;
  logic       e_o, te_o, ack_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  otp_clk_gate_ctrl #(
    .WAKE_CYC(WAKE_CYC),
    .IDLE_CYC(IDLE_CYC),
    .CNT_W   (5)
  ) dut (
    .cp_i   (clk),
    .cd_i   (cd),
    .req_i  (req),
    .act_i  (act),
    .force_i(frc),
    .se_i   (se),
    .e_o    (e_o),
    .te_o   (te_o),
    .ack_o  (ack_o),
    .state_o(state_o)
  );

  // Scoreboard: {state[1:0], e, ack, te}
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phases use the documented STATE encoding.
  // Timing is tracked as elapsed cycles in the phase.
  // wake_age:  cycles spent waking.
  // quiet_age: cycles since DRAIN entry or the last ACT.
  logic [1:0] m_phase   = 2'd0;
  int         wake_age  = 0;
  int         quiet_age = 0;

  task automatic model_step(input logic c, input logic r, input logic a);
    if (c) begin
      m_phase = 2'd0;
    end else begin
      case (m_phase)
        2'd0: if (r) begin
          m_phase  = 2'd1;
          wake_age = 0;
        end
        2'd1: if (!r) begin
          m_phase   = 2'd3;
          quiet_age = 0;
        end else begin
          wake_age++;
          if (wake_age >= WAKE_CYC) m_phase = 2'd2;
        end
        2'd2: if (!r) begin
          m_phase   = 2'd3;
          quiet_age = 0;
        end
        default: if (r) begin
          m_phase = 2'd2;
        end else if (a) begin
          quiet_age = 0;
        end else begin
          quiet_age++;
          if (quiet_age >= IDLE_CYC) m_phase = 2'd0;
        end
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs and queue the expected response
  task automatic drive_cycle(input logic c, input logic r, input logic a,
                             input logic f, input logic s);
    logic exp_e;
    logic exp_ack;
    @(negedge clk);
    cd  = c;
    req = r;
    act = a;
    frc = f;
    se  = s;
    model_step(c, r, a);
    exp_e   = (m_phase != 2'd0) | f;
    exp_ack = (m_phase == 2'd2);
    exp_q.push_back({m_phase, exp_e, exp_ack, s});
  endtask

  task automatic hold(input int n, input logic r, input logic a, input logic f);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, r, a, f, 1'($urandom_range(0, 1)));
  endtask

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
  endtask

  // Monitor: every cycle the DUT presents a new output set; compare after the edge
  initial begin
    logic [4:0] ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("state", state_o, ex[4:3]);
        check("e",     {1'b0, e_o},   {1'b0, ex[2]});
        check("ack",   {1'b0, ack_o}, {1'b0, ex[1]});
        check("te",    {1'b0, te_o},  {1'b0, ex[0]});
      end
    end
  end

  // Stimulus
  initial begin
    int   len;
    logic r_lvl, f_lvl;
    // Reset, with SE toggling under reset
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Wake to ON, then drain fully to OFF
    hold(6, 1'b1, 1'b0, 1'b0);
    hold(20, 1'b0, 1'b0, 1'b0);
    // ACT mid-drain restarts the quiet time
    hold(5, 1'b1, 1'b0, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    hold(1, 1'b0, 1'b1, 1'b0);
    hold(20, 1'b0, 1'b0, 1'b0);
    // REQ at the last DRAIN edge wins -> ON
    hold(5, 1'b1, 1'b0, 1'b0);
    hold(16, 1'b0, 1'b0, 1'b0);
    hold(3, 1'b1, 1'b0, 1'b0);
    // ACT at the last DRAIN edge keeps DRAIN
    hold(16, 1'b0, 1'b0, 1'b0);
    hold(1, 1'b0, 1'b1, 1'b0);
    hold(20, 1'b0, 1'b0, 1'b0);
    // REQ dropped during WAKE: no ACK, DRAIN then OFF
    hold(1, 1'b1, 1'b0, 1'b0);
    hold(20, 1'b0, 1'b0, 1'b0);
    // Reset while ON, then FORCE in OFF
    hold(5, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    hold(3, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(2, 1'b0, 1'b0, 1'b0);
    // Randomized segments
    for (int seg = 0; seg < 150; seg++) begin
      len   = $urandom_range(1, 40);
      r_lvl = 1'($urandom_range(0, 1));
      f_lvl = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < len; i++) begin
        drive_cycle(($urandom_range(0, 99) == 0), r_lvl,
                    ($urandom_range(0, 11) == 0), f_lvl,
                    1'($urandom_range(0, 1)));
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
